// File: rtl/aes_shiftrows_stream.sv
// aes_shiftrows_stream
// Byte-serial forward ShiftRows for the AES encrypt path. A 16-byte state
// arrives one byte per beat in column-major order (byte i = row i%4,
// column i/4) and leaves ShiftRows-permuted, also column-major:
//     out[r][c] = in[r][(c+r) mod 4]
// Two 16-entry ping-pong banks sustain one byte per cycle. One bank fills
// while the other drains.
//
// Optional build macro AES_SR_INVERSE_EN adds the inv_mode input. The
// stage samples inv_mode with byte 0 of each block and stores it with that
// bank. A bank whose stored bit is set is drained with the inverse map
// in[r][(c-r) mod 4]. Without the macro only the forward map exists.
//
// All outputs are decoded from state registers only. No combinational
// path runs from in_* to out_*, or from out_ready to in_ready.
module aes_shiftrows_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef AES_SR_INVERSE_EN
    input  logic              inv_mode,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    // Storage address {bank, byte index}: entries 0..15 are bank 0, 16..31 bank 1.
    logic [DATA_W-1:0] mem_r [32];
    logic [1:0]        full_r;
    logic              wr_bank_r;
    logic [3:0]        wr_idx_r;
    logic              rd_bank_r;
    logic [3:0]        rd_idx_r;
`ifdef AES_SR_INVERSE_EN
    logic [1:0]        inv_r;
`endif

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              rd_inv_s;
    logic [3:0]        rd_addr_s;

    // Maps output position k (row k%4, column k/4) to the stored byte index
    // that lands there. The 2-bit column arithmetic wraps mod 4 for free.
    function automatic logic [3:0] sr_addr(input logic [3:0] k, input logic inv);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] col;
        r = k[1:0];
        c = k[3:2];
        if (inv) begin
            col = c - r;
        end else begin
            col = c + r;
        end
        return {col, r};
    endfunction

    // Handshake decode and read-side output mux, all sourced from registers.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        rd_inv_s   = 1'b0;
        in_ready   = ~full_r[wr_bank_r];
        out_valid  = full_r[rd_bank_r];
`ifdef AES_SR_INVERSE_EN
        rd_inv_s   = inv_r[rd_bank_r];
`else
        rd_inv_s   = 1'b0;
`endif
        rd_addr_s  = sr_addr(rd_idx_r, rd_inv_s);
        out_data   = mem_r[{rd_bank_r, rd_addr_s}];
        if (out_valid && (rd_idx_r == 4'd15)) begin
            out_last = 1'b1;
        end else begin
            out_last = 1'b0;
        end
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = out_valid & out_ready;
    end

    // Bank write port. clr drops any transfer presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_r[i] <= '0;
            end
        end else if (!clr && in_xfer_s) begin
            mem_r[{wr_bank_r, wr_idx_r}] <= in_data;
        end
    end

    // Ping-pong control: write/read pointers, byte indices and full flags.
    // A bank is written only while its flag is clear and read only while it
    // is set, so one edge never sets and clears the same flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            wr_idx_r  <= 4'd0;
            rd_bank_r <= 1'b0;
            rd_idx_r  <= 4'd0;
`ifdef AES_SR_INVERSE_EN
            inv_r     <= 2'b00;
`endif
        end else if (clr) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            wr_idx_r  <= 4'd0;
            rd_bank_r <= 1'b0;
            rd_idx_r  <= 4'd0;
`ifdef AES_SR_INVERSE_EN
            inv_r     <= 2'b00;
`endif
        end else begin
            if (in_xfer_s) begin
                wr_idx_r <= wr_idx_r + 4'd1;
`ifdef AES_SR_INVERSE_EN
                if (wr_idx_r == 4'd0) begin
                    inv_r[wr_bank_r] <= inv_mode;
                end
`endif
                if (wr_idx_r == 4'd15) begin
                    full_r[wr_bank_r] <= 1'b1;
                    wr_bank_r         <= ~wr_bank_r;
                end
            end
            if (out_xfer_s) begin
                rd_idx_r <= rd_idx_r + 4'd1;
                if (rd_idx_r == 4'd15) begin
                    full_r[rd_bank_r] <= 1'b0;
                    rd_bank_r         <= ~rd_bank_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_shiftrows_stream.sv
// Directed bench for aes_shiftrows_stream. The expected byte orders are
// hand-written ShiftRows tables. Build with +define+AES_SR_INVERSE_EN to
// also exercise the inverse map.
module tb_aes_shiftrows_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
`ifdef AES_SR_INVERSE_EN
    logic       inv_mode;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;
    int stall_cnt = 0;
    logic stall_mon = 1'b0;

    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_cyc[$];

    // Hand-computed source byte for each output position.
    logic [7:0] fwd_tbl [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                 8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    logic [7:0] inv_tbl [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                 8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

    aes_shiftrows_stream #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef AES_SR_INVERSE_EN
        .inv_mode  (inv_mode),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Capture output transfers and input stalls mid-cycle, away from the edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
        if (stall_mon && in_valid && !in_ready) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one byte and holds it until accepted (bounded).
    task automatic send_byte(input logic [7:0] d);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            send_byte(base + 8'(i));
        end
    endtask

    task automatic wait_q(input int n);
        int k;
        k = 0;
        while (q_data.size() < n && k < 300) begin
            tick(1);
            k++;
        end
        if (q_data.size() < n) check("out_timeout", q_data.size(), n);
    endtask

    // Compares 16 captured bytes starting at queue offset off.
    task automatic check_block(input string tag, input int off, input logic [7:0] base,
                               input logic inv);
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            e = inv ? inv_tbl[i] : fwd_tbl[i];
            if (off + i < q_data.size()) begin
                check({tag, "_data"}, q_data[off+i], base | e);
                check({tag, "_last"}, q_last[off+i], (i == 15) ? 1 : 0);
            end else begin
                check({tag, "_missing"}, off + i, q_data.size());
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef AES_SR_INVERSE_EN
        inv_mode  = 1'b0;
`endif
        do_reset();

        // Reset state.
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);

        // Single block, latency and forward permutation.
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        check("t1_valid_before", out_valid, 0);
        send_byte(8'h0F);
        check("t1_valid_after", out_valid, 1);
        wait_q(16);
        check_block("t1", 0, 8'h00, 1'b0);

        // Three back-to-back blocks at full rate.
        do_reset();
        stall_cnt = 0;
        stall_mon = 1'b1;
        send_block(8'h20);
        send_block(8'h40);
        send_block(8'h60);
        stall_mon = 1'b0;
        wait_q(48);
        check("t2_in_stalls", stall_cnt, 0);
        if (q_cyc.size() >= 48) check("t2_no_bubble", q_cyc[47] - q_cyc[0], 47);
        check_block("t2a", 0, 8'h20, 1'b0);
        check_block("t2b", 16, 8'h40, 1'b0);
        check_block("t2c", 32, 8'h60, 1'b0);

        // Backpressure with both banks full.
        do_reset();
        out_ready = 1'b0;
        send_block(8'h00);
        check("t3_ready_mid", in_ready, 1);
        send_block(8'h10);
        check("t3_ready_full", in_ready, 0);
        check("t3_valid_full", out_valid, 1);
        check("t3_data_stall", out_data, 8'h00);
        tick(5);
        check("t3_data_hold", out_data, 8'h00);
        check("t3_last_hold", out_last, 0);
        check("t3_ready_hold", in_ready, 0);
        out_ready = 1'b1;
        tick(15);
        check("t3_ready_15", in_ready, 0);
        tick(1);
        check("t3_ready_16", in_ready, 1);
        wait_q(32);
        check_block("t3a", 0, 8'h00, 1'b0);
        check_block("t3b", 16, 8'h10, 1'b0);

        // Flush a partial block, then a clean block.
        tick(2);
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
        for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i));
        clr      = 1'b1;
        in_data  = 8'hEE;
        in_valid = 1'b1;
        tick(1);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t4_clr_ready", in_ready, 1);
        check("t4_clr_valid", out_valid, 0);
        send_block(8'h10);
        wait_q(16);
        tick(20);
        check("t4_count", q_data.size(), 16);
        check_block("t4", 0, 8'h10, 1'b0);

        // Asynchronous reset in the middle of a drain.
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
        send_block(8'h30);
        wait_q(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_data", out_data, 0);
        tick(1);
        #2;
        rst_n = 1'b1;
        tick(1);
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
        send_block(8'h60);
        wait_q(16);
        check_block("t5", 0, 8'h60, 1'b0);

`ifdef AES_SR_INVERSE_EN
        // Inverse block with inv_mode dropped after byte 0, then a forward block.
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
        inv_mode = 1'b1;
        send_byte(8'h00);
        inv_mode = 1'b0;
        for (int i = 1; i < 16; i++) send_byte(8'(i));
        send_block(8'h10);
        wait_q(32);
        check_block("t6_inv", 0, 8'h00, 1'b1);
        check_block("t6_fwd", 16, 8'h10, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
